// File: rtl/cpu_pkg.sv
// Shared CPU types and constants used by the instruction fetch stage.
package cpu_pkg;

    localparam int unsigned XLEN     = 32;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;
    localparam logic [31:0] PC_STEP  = 32'd4;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } ifu_state_t;

    // IF/ID payload: latched instruction word and the PC+4 that goes with it
    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc4;
    } if_id_t;

    // True when pc is word-aligned and its word index lies inside the ROM
    function automatic logic pc_in_range(input logic [XLEN-1:0] pc,
                                         input int unsigned     depth);
        return (pc[1:0] == 2'b00) && ({2'b00, pc[XLEN-1:2]} < 32'(depth));
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with synchronous reset, flush (bubble), load and hold.
module if_id_reg
    import cpu_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   load,
    input  logic   flush,
    input  if_id_t d,
    output if_id_t q,
    output logic   valid
);

    // Reset and flush both leave a nop bubble; otherwise load or hold
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            q     <= '{inst: NOP_WORD, pc4: '0};
            valid <= 1'b0;
        end else if (load) begin
            q     <= d;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: PC register, next-PC mux, IF/ID latch and fetch counter.
// Define IFU_RANGE_CHECK_EN to enable the alignment/range fault and HALT state.
module inst_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned ROM_DEPTH = 256
) (
    input  logic        Clk,
    input  logic        Reset,
    output logic [31:0] InstAddr,
    input  logic [31:0] InstIn,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    output logic [31:0] IfIdInst,
    output logic [31:0] IfIdPC4,
    output logic        IfIdValid,
    output logic [31:0] FetchCount
`ifdef IFU_RANGE_CHECK_EN
    ,
    output logic        FetchFault
`endif
);

`ifdef IFU_RANGE_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    ifu_state_t  state_q;
    ifu_state_t  state_d;
    logic [31:0] pc_q;
    logic [31:0] pc_plus4_c;
    logic [31:0] pc_next_c;
    logic        pc_fault_c;
    logic        pc_load_c;
    logic        ifid_load_c;
    logic        ifid_flush_c;
    logic        cnt_inc_c;
    logic [31:0] fetch_count_q;
    if_id_t      ifid_d;
    if_id_t      ifid_q;
    logic        ifid_valid_q;

    assign pc_plus4_c = pc_q + PC_STEP;

    // Redirect beats stall beats sequential advance
    always_comb begin
        pc_next_c = pc_plus4_c;
        if (BranchTaken) begin
            pc_next_c = BranchTarget;
        end else if (Stall) begin
            pc_next_c = pc_q;
        end
    end

    assign pc_fault_c = CHECK_EN && !pc_in_range(pc_next_c, ROM_DEPTH);

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a faulting next PC parks the unit until reset
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (pc_fault_c) state_d = HALT;
            HALT:    state_d = HALT;
            default: state_d = RUN;
        endcase
    end

    // Output/control decode
    always_comb begin
        pc_load_c    = 1'b0;
        ifid_load_c  = 1'b0;
        ifid_flush_c = 1'b0;
        cnt_inc_c    = 1'b0;
        case (state_q)
            RUN: begin
                if (pc_fault_c || BranchTaken) begin
                    pc_load_c    = 1'b1;
                    ifid_flush_c = 1'b1;
                end else if (!Stall) begin
                    pc_load_c   = 1'b1;
                    ifid_load_c = 1'b1;
                    cnt_inc_c   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_q <= RESET_PC;
        end else if (pc_load_c) begin
            pc_q <= pc_next_c;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            fetch_count_q <= '0;
        end else if (cnt_inc_c) begin
            fetch_count_q <= fetch_count_q + 32'd1;
        end
    end

    assign ifid_d = '{inst: InstIn, pc4: pc_plus4_c};

    if_id_reg u_if_id_reg (
        .clk   (Clk),
        .rst   (Reset),
        .load  (ifid_load_c),
        .flush (ifid_flush_c),
        .d     (ifid_d),
        .q     (ifid_q),
        .valid (ifid_valid_q)
    );

`ifdef IFU_RANGE_CHECK_EN
    logic fault_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= (state_d == HALT);
        end
    end

    assign FetchFault = fault_q;
`endif

    assign InstAddr   = pc_q;
    assign IfIdInst   = ifid_q.inst;
    assign IfIdPC4    = ifid_q.pc4;
    assign IfIdValid  = ifid_valid_q;
    assign FetchCount = fetch_count_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Testbench for inst_fetch_unit: directed scenarios plus random stimulus vs a reference model.
module tb_inst_fetch_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] InstAddr;
    logic [31:0] InstIn;
    logic        Stall;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic [31:0] IfIdInst;
    logic [31:0] IfIdPC4;
    logic        IfIdValid;
    logic [31:0] FetchCount;
`ifdef IFU_RANGE_CHECK_EN
    logic        FetchFault;
`endif

    logic [31:0] mem [256];

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model of the architecturally visible state
    logic [31:0] m_pc, m_inst, m_pc4, m_cnt;
    logic        m_valid, m_halt;

    always #5 Clk = ~Clk;

    assign InstIn = mem[InstAddr[9:2]];

    inst_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .ROM_DEPTH (256)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .InstAddr     (InstAddr),
        .InstIn       (InstIn),
        .Stall        (Stall),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .IfIdInst     (IfIdInst),
        .IfIdPC4      (IfIdPC4),
        .IfIdValid    (IfIdValid),
        .FetchCount   (FetchCount)
`ifdef IFU_RANGE_CHECK_EN
        ,
        .FetchFault   (FetchFault)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_update(input logic r, input logic s, input logic b, input logic [31:0] t);
        logic [31:0] np;
        if (r) begin
            m_pc = 32'h0; m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_cnt = 32'h0; m_halt = 1'b0;
            return;
        end
        if (m_halt) return;
        np = b ? t : (s ? m_pc : m_pc + 32'd4);
`ifdef IFU_RANGE_CHECK_EN
        if (np[1:0] != 2'b00 || (np >> 2) >= 32'd256) begin
            m_pc = np; m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_halt = 1'b1;
            return;
        end
`endif
        if (b) begin
            m_pc = t; m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end else if (!s) begin
            m_inst  = mem[m_pc[9:2]];
            m_pc4   = m_pc + 32'd4;
            m_valid = 1'b1;
            m_cnt   = m_cnt + 32'd1;
            m_pc    = m_pc + 32'd4;
        end
    endtask

    task automatic check_all();
        check("InstAddr", InstAddr, m_pc);
        check("IfIdInst", IfIdInst, m_inst);
        check("IfIdPC4", IfIdPC4, m_pc4);
        check("IfIdValid", 32'(IfIdValid), 32'(m_valid));
        check("FetchCount", FetchCount, m_cnt);
`ifdef IFU_RANGE_CHECK_EN
        check("FetchFault", 32'(FetchFault), 32'(m_halt));
`endif
    endtask

    // Drive one cycle of inputs (called at a negedge), advance the model, check after the edge
    task automatic step(input logic r, input logic s, input logic b, input logic [31:0] t);
        Reset = r; Stall = s; BranchTaken = b; BranchTarget = t;
        model_update(r, s, b, t);
        @(posedge Clk);
        @(negedge Clk);
        check_all();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0] = 32'h3401_0005;
        mem[1] = 32'h3402_0005;
        mem[2] = 32'h1022_0002;
        mem[5] = 32'h3409_000A;
        Reset = 1'b1; Stall = 1'b0; BranchTaken = 1'b0; BranchTarget = 32'h0;
        m_pc = 32'h0; m_inst = 32'h0; m_pc4 = 32'h0; m_cnt = 32'h0; m_valid = 1'b0; m_halt = 1'b0;
        @(negedge Clk);

        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("rst_addr", InstAddr, 32'h0);

        // Three straight fetches
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
        check("seq_inst", IfIdInst, 32'h1022_0002);
        check("seq_pc4", IfIdPC4, 32'h0000_000C);
        check("seq_cnt", FetchCount, 32'd3);
        check("seq_addr", InstAddr, 32'h0000_000C);

        // Redirect to 0x14: one bubble, then word 5
        step(1'b0, 1'b0, 1'b1, 32'h0000_0014);
        check("br_addr", InstAddr, 32'h0000_0014);
        check("br_valid", 32'(IfIdValid), 32'h0);
        check("br_inst", IfIdInst, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("br_next_inst", IfIdInst, 32'h3409_000A);
        check("br_next_pc4", IfIdPC4, 32'h0000_0018);

        // Stall two cycles at 0x08
        step(1'b0, 1'b0, 1'b1, 32'h0000_0008);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check("stall_addr", InstAddr, 32'h0000_0008);
        check("stall_cnt", FetchCount, 32'd4);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("resume_inst", IfIdInst, 32'h1022_0002);
        check("resume_pc4", IfIdPC4, 32'h0000_000C);

        // Branch wins over simultaneous stall
        step(1'b0, 1'b1, 1'b1, 32'h0000_0020);
        check("brstall_addr", InstAddr, 32'h0000_0020);
        check("brstall_valid", 32'(IfIdValid), 32'h0);

        // Reset while stalling
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        check("rststall_cnt", FetchCount, 32'h0);
        check("rststall_addr", InstAddr, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);

        // Out-of-range redirect
        step(1'b0, 1'b0, 1'b1, 32'h0000_0400);
        step(1'b0, 1'b0, 1'b0, 32'h0);
`ifdef IFU_RANGE_CHECK_EN
        check("halt_fault", 32'(FetchFault), 32'h1);
        check("halt_addr", InstAddr, 32'h0000_0400);
        step(1'b0, 1'b1, 1'b1, 32'h0000_0010);
        check("halt_ignore", InstAddr, 32'h0000_0400);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("halt_clear", 32'(FetchFault), 32'h0);
`else
        check("alias_inst", IfIdInst, 32'h3401_0005);
        check("alias_pc4", IfIdPC4, 32'h0000_0404);
        // PC wraps modulo 2^32
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("wrap_addr", InstAddr, 32'h0);
        check("wrap_pc4", IfIdPC4, 32'h0);
`endif

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic        r, s, b;
            logic [31:0] t;
            r = ($urandom_range(0, 99) < 3);
            s = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 9) == 0) t = $urandom;
            else t = 32'($urandom_range(0, 300)) << 2;
            step(r, s, b, t);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch_unit.md
# inst_fetch_unit

Instruction fetch stage (IF) of the pipelined CPU. Issues instruction addresses to the combinational instruction memory (word index = Addr[9:2]), captures the returned word into the IF/ID pipeline register, and handles stalls and branch redirects with a one-slot flush. Sits between the PC/branch logic of ID/EX and the instruction memory, feeding the decode stage.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; word-aligned.
- ROM_DEPTH, 256, number of 32-bit words in instruction memory; used by the range check only.
- Clk  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset; sampled on the Clk rising edge.
- InstAddr  out  32  current PC driven to instruction memory Addr.
- InstIn  in  32  instruction word returned combinationally from instruction memory.
- Stall  in  1  hold PC and IF/ID (load-use hazard from ID).
- BranchTaken  in  1  redirect request from the branch-resolve stage.
- BranchTarget  in  32  redirect address; valid when BranchTaken=1.
- IfIdInst  out  32  latched instruction.
- IfIdPC4  out  32  latched PC+4 of that instruction.
- IfIdValid  out  1  IF/ID holds a real (non-bubble) instruction.
- FetchCount  out  32  number of valid instructions latched since reset.
- FetchFault  out  1  range/alignment fault; present only with IFU_RANGE_CHECK_EN.

## Operation
- State machine: RUN, HALT. HALT is reachable only with IFU_RANGE_CHECK_EN.
- Per-edge priority: Reset > BranchTaken > Stall > normal advance.
- Reset: PC=RESET_PC, IfIdInst=0, IfIdPC4=0, IfIdValid=0, FetchCount=0, FetchFault=0, state=RUN.
- Normal (RUN, no Stall, no branch):
  - PC <= PC+4.
  - IfIdInst <= InstIn.
  - IfIdPC4 <= PC+4.
  - IfIdValid <= 1.
  - FetchCount += 1.
- Stall=1 (no branch): PC, IF/ID and FetchCount hold.
- BranchTaken=1:
  - PC <= BranchTarget.
  - IF/ID <= bubble: IfIdInst=0 (nop), IfIdValid=0, IfIdPC4=0.
  - FetchCount holds.
  - Overrides a simultaneous Stall.
- PC arithmetic: 32-bit, modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
- FetchCount is 32-bit and wraps silently.
- InstAddr = PC at all times (combinational from the register).

## Timing
- Fetch latency: PC presented in cycle N; instruction visible on IfIdInst after the edge ending cycle N.
- Throughput: one instruction per cycle when not stalled.
- First edge after Reset deasserts latches word at RESET_PC.
- Branch penalty inside this unit: one bubble. Older wrong-path instructions already in ID are flushed by downstream logic, not here.
- Reset asserted mid-stall or mid-redirect: reset values on that same edge; pending requests are discarded.

## Configuration
- IFU_RANGE_CHECK_EN defined:
  - Fault condition: on a RUN edge, the next PC is misaligned (bits[1:0]≠0) or its word index ≥ ROM_DEPTH.
  - On fault: enter HALT, set FetchFault=1, PC and FetchCount freeze, IF/ID <= bubble.
  - HALT ignores Stall and BranchTaken; only Reset exits.
- IFU_RANGE_CHECK_EN undefined:
  - No HALT state and no FetchFault port.
  - Out-of-range PC aliases through Addr[9:2]; low address bits are ignored.

## Structure
- Shared package cpu_pkg:
  - NOP_WORD (32'h0).
  - PC_STEP (4).
  - Fetch state enum ifu_state_t.
- Optional sub-module if_id_reg: IF/ID register with load, flush and hold controls.
- PC register, next-PC mux and the range check stay in the top module.

## Test plan
- Reset, then release; memory holds 0x34010005, 0x34020005, 0x10220002 at words 0–2 → after 3 edges IfIdInst=0x10220002, IfIdPC4=0x0C, FetchCount=3, InstAddr=0x0C.
- Stall=1 for 2 cycles at PC=0x08 → InstAddr stays 0x08, IF/ID and FetchCount unchanged; resumes with 0x08 on the next edge.
- BranchTaken=1, BranchTarget=0x14 while PC=0x0C → next cycle InstAddr=0x14, IfIdValid=0, IfIdInst=0; following edge latches 0x3409000A with IfIdPC4=0x18.
- BranchTaken and Stall together → redirect taken, bubble inserted.
- Reset asserted during Stall → all outputs at reset values on that edge.
- With IFU_RANGE_CHECK_EN, BranchTarget=0x400 (ROM_DEPTH=256) → FetchFault=1, state HALT, PC frozen at 0x400, IfIdValid=0. Further Stall/BranchTaken ignored; Reset clears. Without the macro, the same target fetches word 0.
